// File: rtl/sdram_init_seq_if.sv
// Command/status bundle between the SDRAM power-up sequencer and the controller's command mux.
// init_req is a one-cycle pulse; it is acted on only while sdram_init_done is high.
interface sdram_init_seq_if;
    logic        init_req;
    logic        sdr_cke;
    logic        sdr_cs_n;
    logic        sdr_ras_n;
    logic        sdr_cas_n;
    logic        sdr_we_n;
    logic [12:0] sdr_addr;
    logic [1:0]  sdr_ba;
    logic        sdram_init_done;
    logic        init_busy;
    logic [2:0]  fsm_state;

    modport master (
        input  init_req,
        output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
        output sdr_addr, sdr_ba, sdram_init_done, init_busy, fsm_state
    );

    modport slave (
        output init_req,
        input  sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
        input  sdr_addr, sdr_ba, sdram_init_done, init_busy, fsm_state
    );
endinterface

// File: rtl/sdram_init_seq.sv
// SDRAM power-up sequencer: NOP wait, PRECHARGE ALL, NUM_AREF x AUTO REFRESH, LOAD MODE.
// Outputs are registered from the state being entered, so the state register and the bus agree.
module sdram_init_seq #(
    parameter int          INIT_WAIT = 10000,
    parameter int          TRP       = 3,
    parameter int          TRFC      = 8,
    parameter int          NUM_AREF  = 8,
    parameter int          TMRD      = 2,
    parameter logic [12:0] MODE_REG  = 13'h033
) (
    input logic clk,
    input logic rst,
    sdram_init_seq_if.master bus
);
    localparam int MAX_A = (INIT_WAIT > TRP) ? INIT_WAIT : TRP;
    localparam int MAX_B = (TRFC > TMRD) ? TRFC : TMRD;
    localparam int MAX_V = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = (MAX_V > 1) ? $clog2(MAX_V) : 1;
    localparam int AW    = $clog2(NUM_AREF + 1);

    // Wait states hold (cycles - 1) NOPs; the counter is loaded with that count minus one.
    localparam logic [CW-1:0] INIT_LOAD = CW'(INIT_WAIT - 1);
    localparam logic [CW-1:0] TRP_LOAD  = CW'((TRP  > 1) ? TRP  - 2 : 0);
    localparam logic [CW-1:0] TRFC_LOAD = CW'((TRFC > 1) ? TRFC - 2 : 0);
    localparam logic [CW-1:0] TMRD_LOAD = CW'((TMRD > 1) ? TMRD - 2 : 0);
    localparam logic [AW-1:0] AREF_LOAD = AW'(NUM_AREF);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    typedef enum logic [2:0] {
        IDLE_WAIT, PRE, TRP_WAIT, AREF, TRFC_WAIT, LMR, TMRD_WAIT, DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [AW-1:0] aref_cnt;
    logic          armed;
    logic          cke;
    logic [3:0]    cmd;
    logic [12:0]   addr;
    logic          done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE_WAIT;
            wait_cnt <= INIT_LOAD;
            aref_cnt <= AREF_LOAD;
            armed    <= 1'b0;
            cke      <= 1'b0;
            cmd      <= CMD_NOP;
            addr     <= '0;
            done     <= 1'b0;
        end else begin
            cmd  <= CMD_NOP;
            addr <= '0;
            case (state)
                // The first cycle of the wait only raises CKE; counting starts on the next one.
                IDLE_WAIT: begin
                    cke <= 1'b1;
                    if (!armed) begin
                        armed <= 1'b1;
                    end else if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        state <= PRE;
                        cmd   <= CMD_PRE;
                        addr  <= 13'h0400;
                    end
                end
                PRE: begin
                    if (TRP > 1) begin
                        state    <= TRP_WAIT;
                        wait_cnt <= TRP_LOAD;
                    end else begin
                        state    <= AREF;
                        cmd      <= CMD_AREF;
                        aref_cnt <= aref_cnt - 1'b1;
                    end
                end
                TRP_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        state    <= AREF;
                        cmd      <= CMD_AREF;
                        aref_cnt <= aref_cnt - 1'b1;
                    end
                end
                AREF: begin
                    if (TRFC > 1) begin
                        state    <= TRFC_WAIT;
                        wait_cnt <= TRFC_LOAD;
                    end else if (aref_cnt != '0) begin
                        state    <= AREF;
                        cmd      <= CMD_AREF;
                        aref_cnt <= aref_cnt - 1'b1;
                    end else begin
                        state <= LMR;
                        cmd   <= CMD_LMR;
                        addr  <= MODE_REG;
                    end
                end
                TRFC_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else if (aref_cnt != '0) begin
                        state    <= AREF;
                        cmd      <= CMD_AREF;
                        aref_cnt <= aref_cnt - 1'b1;
                    end else begin
                        state <= LMR;
                        cmd   <= CMD_LMR;
                        addr  <= MODE_REG;
                    end
                end
                LMR: begin
                    if (TMRD > 1) begin
                        state    <= TMRD_WAIT;
                        wait_cnt <= TMRD_LOAD;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                TMRD_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.init_req) begin
                        state    <= IDLE_WAIT;
                        done     <= 1'b0;
                        wait_cnt <= INIT_LOAD;
                        aref_cnt <= AREF_LOAD;
                        armed    <= 1'b0;
                    end
                end
                default: state <= IDLE_WAIT;
            endcase
        end
    end

    assign bus.sdr_cke         = cke;
    assign bus.sdr_cs_n        = cmd[3];
    assign bus.sdr_ras_n       = cmd[2];
    assign bus.sdr_cas_n       = cmd[1];
    assign bus.sdr_we_n        = cmd[0];
    assign bus.sdr_addr        = addr;
    assign bus.sdr_ba          = 2'b00;
    assign bus.sdram_init_done = done;
    assign bus.init_busy       = ~done;
    assign bus.fsm_state       = state;
endmodule

// File: tb/tb_sdram_init_seq.sv
// Directed bench: a small-parameter sequencer for schedule, reset and re-init cases,
// plus a default-parameter instance checked for the full-length power-up sequence.
module tb_sdram_init_seq;
    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PREC = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] LMR  = 4'b0000;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst_d = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [17:0] exp_q[$];

    sdram_init_seq_if bus_s ();
    sdram_init_seq_if bus_d ();

    sdram_init_seq #(
        .INIT_WAIT(16), .TRP(2), .TRFC(4), .NUM_AREF(2), .TMRD(2), .MODE_REG(13'h033)
    ) u_small (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    sdram_init_seq u_dflt (
        .clk (clk),
        .rst (rst_d),
        .bus (bus_d)
    );

    logic [3:0] cmd_s;
    logic [3:0] cmd_d;
    assign cmd_s = {bus_s.sdr_cs_n, bus_s.sdr_ras_n, bus_s.sdr_cas_n, bus_s.sdr_we_n};
    assign cmd_d = {bus_d.sdr_cs_n, bus_d.sdr_ras_n, bus_d.sdr_cas_n, bus_d.sdr_we_n};

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_cke"},   32'(bus_s.sdr_cke), 32'd0);
        check({pfx, "_cmd"},   32'(cmd_s), 32'(NOP));
        check({pfx, "_addr"},  32'(bus_s.sdr_addr), 32'd0);
        check({pfx, "_ba"},    32'(bus_s.sdr_ba), 32'd0);
        check({pfx, "_done"},  32'(bus_s.sdram_init_done), 32'd0);
        check({pfx, "_busy"},  32'(bus_s.init_busy), 32'd1);
        check({pfx, "_state"}, 32'(bus_s.fsm_state), 32'd0);
    endtask

    // Main directed sequence on the small instance.
    task automatic run_small();
        logic [17:0] e;
        int pre_at;
        int done_at;
        int aref_n;
        int aref_at;

        bus_s.init_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");

        // Nominal schedule, cycles 0..31; init_req pulsed at edge 10 must be ignored.
        for (int c = 0; c < 32; c++) begin
            e = {NOP, 13'h0000, 1'b0};
            if (c == 16) e = {PREC, 13'h0400, 1'b0};
            if (c == 18 || c == 22) e = {AREF, 13'h0000, 1'b0};
            if (c == 26) e = {LMR, 13'h0033, 1'b0};
            if (c >= 28) e = {NOP, 13'h0000, 1'b1};
            exp_q.push_back(e);
        end
        rst   = 1'b0;
        rst_d = 1'b0;
        cyc   = -1;
        for (int c = 0; c < 32; c++) begin
            step();
            bus_s.init_req = (cyc == 9);
            check($sformatf("nom_c%0d", cyc),
                  32'({cmd_s, bus_s.sdr_addr, bus_s.sdram_init_done}), 32'(exp_q.pop_front()));
            if (cyc == 0) check("nom_cke_c0", 32'(bus_s.sdr_cke), 32'd1);
            if (cyc == 28) begin
                check("nom_busy_c28", 32'(bus_s.init_busy), 32'd0);
                check("nom_state_c28", 32'(bus_s.fsm_state), 32'd7);
                check("nom_ba_c28", 32'(bus_s.sdr_ba), 32'd0);
            end
        end

        // Re-init pulse sampled at edge 40.
        while (cyc < 39) step();
        check("reinit_done_c39", 32'(bus_s.sdram_init_done), 32'd1);
        bus_s.init_req = 1'b1;
        step();
        bus_s.init_req = 1'b0;
        check("reinit_done_c40", 32'(bus_s.sdram_init_done), 32'd0);
        check("reinit_busy_c40", 32'(bus_s.init_busy), 32'd1);
        check("reinit_cke_c40", 32'(bus_s.sdr_cke), 32'd1);
        check("reinit_cmd_c40", 32'(cmd_s), 32'(NOP));
        pre_at  = -1;
        done_at = -1;
        while (cyc < 72) begin
            step();
            if (cmd_s == PREC && pre_at < 0) begin
                pre_at = cyc;
                check("reinit_pre_a10", 32'(bus_s.sdr_addr[10]), 32'd1);
            end
            if (bus_s.sdram_init_done && done_at < 0) done_at = cyc;
        end
        check("reinit_pre_cycle", 32'(pre_at), 32'd57);
        check("reinit_done_cycle", 32'(done_at), 32'd69);

        // Reset asserted at cycle 20, in the TRFC wait after the first AREF.
        rst = 1'b1;
        step();
        step();
        rst    = 1'b0;
        cyc    = -1;
        aref_n = 0;
        while (cyc < 19) begin
            step();
            if (cmd_s == AREF) aref_n++;
        end
        check("midrst_aref_before", 32'(aref_n), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_vals("midrst");
        aref_n  = 0;
        pre_at  = -1;
        aref_at = -1;
        while (cyc < 40) begin
            step();
            if (cmd_s == PREC && pre_at < 0) pre_at = cyc;
            if (cmd_s == AREF) begin
                if (pre_at < 0) aref_n++;
                else if (aref_at < 0) aref_at = cyc;
            end
        end
        check("midrst_pre_cycle", 32'(pre_at), 32'd37);
        check("midrst_aref_early", 32'(aref_n), 32'd0);
        check("midrst_aref_first", 32'(aref_at), 32'd39);
    endtask

    // Default-parameter instance: full-length sequence from its own release.
    task automatic run_default();
        int d_pre = -1;
        int d_lmr = -1;
        int d_done = -1;
        int d_aref_n = 0;
        int d_first = -1;
        int d_last = -1;
        int d_gap_bad = 0;
        int d_adj = 0;
        logic [12:0] d_lmr_addr = '0;
        logic [3:0] prev = NOP;

        bus_d.init_req = 1'b0;
        wait (rst_d == 1'b0);
        for (int c = 0; c < 10080; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (cmd_d != NOP && prev != NOP) d_adj++;
            if (cmd_d == PREC && d_pre < 0) d_pre = c;
            if (cmd_d == AREF) begin
                if (d_last >= 0 && c - d_last != 8) d_gap_bad++;
                if (d_first < 0) d_first = c;
                d_last = c;
                d_aref_n++;
            end
            if (cmd_d == LMR && d_lmr < 0) begin
                d_lmr = c;
                d_lmr_addr = bus_d.sdr_addr;
            end
            if (bus_d.sdram_init_done && d_done < 0) d_done = c;
            prev = cmd_d;
        end
        check("dflt_pre_cycle", 32'(d_pre), 32'd10000);
        check("dflt_aref_first", 32'(d_first), 32'd10003);
        check("dflt_aref_last", 32'(d_last), 32'd10059);
        check("dflt_aref_count", 32'(d_aref_n), 32'd8);
        check("dflt_aref_gap", 32'(d_gap_bad), 32'd0);
        check("dflt_lmr_cycle", 32'(d_lmr), 32'd10067);
        check("dflt_lmr_addr", 32'(d_lmr_addr), 32'h033);
        check("dflt_done_cycle", 32'(d_done), 32'd10069);
        check("dflt_adjacent_cmds", 32'(d_adj), 32'd0);
        check("dflt_busy_end", 32'(bus_d.init_busy), 32'd0);
    endtask

    initial begin
        fork
            run_small();
            run_default();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
